dmem_byte_sequencer: RTL and testbench

- Sequences MEM-stage loads and stores onto a byte-serial data memory port.
- One access of 1, 2 or 4 bytes becomes N single-byte transactions with a per-byte ready handshake.
- Holds the pipeline with `stall` while the transfer runs.
- Assembles load data with sign or zero extension. Sits between the MEM-stage control signals (size, funct3) and the data memory.

---
 rtl/dmem_byte_sequencer.sv | 168 ++++++++++++++++
 tb/tb_dmem_byte_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_byte_sequencer.sv
// Breaks one MEM-stage load/store of 1, 2 or 4 bytes into single-byte memory
// transactions, stalling the pipeline until the access completes.
module dmem_byte_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [2:0]        size,
    input  logic              unsigned_ld,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ready,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [1:0]        last_q, last_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              uns_q, uns_d;
    logic [31:0]       asm_q, asm_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [31:0]       wshift;

    function automatic logic [31:0] extend(input logic [31:0] a, input logic [1:0] last,
                                           input logic uns);
        case (last)
            2'd0:    extend = {{24{a[7] & ~uns}}, a[7:0]};
            2'd1:    extend = {{16{a[15] & ~uns}}, a[15:0]};
            default: extend = a;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            tcnt_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            asm_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            tcnt_q  <= tcnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            asm_q   <= asm_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Byte handshake: mem_en holds one byte request (mem_addr/mem_we/mem_wdata
    // stable) until the memory returns mem_ready=1, which completes that byte.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        tcnt_d    = tcnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        uns_d     = uns_q;
        asm_d     = asm_q;
        rdata_d   = rdata_q;
        err_d     = 1'b0;
        stall     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        wshift    = wdata_q >> {cnt_q, 3'b000};

        case (state_q)
            IDLE: begin
                if (MemReadM || MemWriteM) begin
                    stall   = 1'b1;
                    addr_d  = addr;
                    wdata_d = wdata;
                    we_d    = MemWriteM;
                    uns_d   = unsigned_ld;
                    cnt_d   = '0;
                    tcnt_d  = '0;
                    state_d = XFER;
                    case (size)
                        3'b001:  last_d = 2'd0;
                        3'b010:  last_d = 2'd1;
                        default: last_d = 2'd3;
                    endcase
                end
            end
            XFER: begin
                stall     = 1'b1;
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q + ADDR_W'(cnt_q);
                mem_wdata = wshift[7:0];
                if (mem_ready) begin
                    if (!we_q) begin
                        case (cnt_q)
                            2'd0:    asm_d[7:0]   = mem_rdata;
                            2'd1:    asm_d[15:8]  = mem_rdata;
                            2'd2:    asm_d[23:16] = mem_rdata;
                            default: asm_d[31:24] = mem_rdata;
                        endcase
                    end
                    cnt_d  = cnt_q + 2'd1;
                    tcnt_d = '0;
                    if (cnt_q == last_q) begin
                        state_d = DONE;
                        if (!we_q) rdata_d = extend(asm_d, last_q, uns_q);
                    end
                end else if (TIMEOUT != 0 && tcnt_q == TLAST) begin
                    // Abort: a partially assembled load is discarded.
                    state_d = DONE;
                    err_d   = 1'b1;
                    if (!we_q) rdata_d = '0;
                end else begin
                    tcnt_d = tcnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rdata       = rdata_q;
    assign err         = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_dmem_byte_sequencer.sv
// Directed bench for dmem_byte_sequencer: a driver plays the pipeline and the
// byte memory, a monitor checks byte transactions and DONE results from queues.
module tb_dmem_byte_sequencer;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        MemReadM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [2:0]  size = 3'b000;
  logic        unsigned_ld = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        stall;
  logic        err;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [1:0]  dbg_state;

  int checks = 0;
  int failures = 0;
  int stall_cnt = 0;
  logic [31:0] last_rdata = '0;

  // {we, addr[31:0], wdata[7:0]}
  logic [40:0] exp_txn_q[$];
  // {err, stall_cycles[7:0], rdata[31:0]}
  logic [40:0] exp_done_q[$];

  dmem_byte_sequencer #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
    .size(size), .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .err(err), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_txn(input logic we, input logic [31:0] a, input logic [7:0] d);
    exp_txn_q.push_back({we, a, d});
  endtask

  task automatic push_done(input logic e, input int stalls, input logic [31:0] r);
    exp_done_q.push_back({e, 8'(stalls), r});
    last_rdata = r;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 20; k++) begin
      if (dbg_state == 2'd0) break;
      step();
    end
    if (k == 20) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout actual=%0h required=0", dbg_state);
    end
  endtask

  // driver: issue one request in IDLE, then answer n_ready bytes after `waits`
  // idle cycles each; n_ready = 0 leaves the memory silent until timeout.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] sz,
                            input logic uns, input logic [31:0] a, input logic [31:0] wd,
                            input logic [31:0] rbytes, input int n_ready, input int waits);
    MemReadM = rd;
    MemWriteM = wr;
    size = sz;
    unsigned_ld = uns;
    addr = a;
    wdata = wd;
    step();
    MemReadM = 1'b0;
    MemWriteM = 1'b0;
    addr = 32'h5555_5555;
    wdata = 32'hAAAA_AAAA;
    if (n_ready == 0) begin
      repeat (TO) step();
    end else begin
      for (int i = 0; i < n_ready; i++) begin
        repeat (waits) step();
        mem_ready = 1'b1;
        mem_rdata = rbytes[8*i +: 8];
        step();
        mem_ready = 1'b0;
        mem_rdata = 8'h00;
      end
    end
    wait_idle();
  endtask

  // monitor
  always @(negedge clk) begin
    logic [40:0] e;
    if (rst) begin
      stall_cnt = 0;
    end else begin
      if (stall) stall_cnt++;
      if (err && dbg_state != 2'd2) check("err_outside_done", {63'd0, err}, 64'd0);
      if (mem_en && mem_ready) begin
        if (exp_txn_q.size() == 0) begin
          check("unexpected_txn", {31'd0, mem_addr}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_txn_q.pop_front();
          check("txn_we", {63'd0, mem_we}, {63'd0, e[40]});
          check("txn_addr", {32'd0, mem_addr}, {32'd0, e[39:8]});
          if (e[40]) check("txn_wdata", {56'd0, mem_wdata}, {56'd0, e[7:0]});
        end
      end
      if (dbg_state == 2'd2) begin
        if (exp_done_q.size() == 0) begin
          check("unexpected_done", {32'd0, rdata}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_done_q.pop_front();
          check("done_err", {63'd0, err}, {63'd0, e[40]});
          check("done_rdata", {32'd0, rdata}, {32'd0, e[31:0]});
          check("done_stall_cycles", 64'(stall_cnt), {56'd0, e[39:32]});
          check("done_mem_en", {63'd0, mem_en}, 64'd0);
        end
        stall_cnt = 0;
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", {62'd0, dbg_state}, 64'd0);
    check("rst_rdata", {32'd0, rdata}, 64'd0);
    check("rst_err", {63'd0, err}, 64'd0);
    check("rst_mem_en", {63'd0, mem_en}, 64'd0);
    check("rst_mem_we", {63'd0, mem_we}, 64'd0);
    check("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
    check("rst_mem_wdata", {56'd0, mem_wdata}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step();

    // signed byte load
    push_txn(1'b0, 32'h100, 8'h00);
    push_done(1'b0, 2, 32'hFFFF_FF80);
    run_access(1'b1, 1'b0, 3'b001, 1'b0, 32'h100, 32'h0, 32'h0000_0080, 1, 0);

    // unsigned half load
    push_txn(1'b0, 32'h200, 8'h00);
    push_txn(1'b0, 32'h201, 8'h00);
    push_done(1'b0, 3, 32'h0000_F234);
    run_access(1'b1, 1'b0, 3'b010, 1'b1, 32'h200, 32'h0, 32'h0000_F234, 2, 0);

    // word store, rdata keeps the previous load
    push_txn(1'b1, 32'h300, 8'hEF);
    push_txn(1'b1, 32'h301, 8'hBE);
    push_txn(1'b1, 32'h302, 8'hAD);
    push_txn(1'b1, 32'h303, 8'hDE);
    push_done(1'b0, 5, 32'h0000_F234);
    run_access(1'b0, 1'b1, 3'b100, 1'b0, 32'h300, 32'hDEAD_BEEF, 32'h0, 4, 0);

    // word load with 2 wait cycles per byte across the address wrap
    push_txn(1'b0, 32'hFFFF_FFFE, 8'h00);
    push_txn(1'b0, 32'hFFFF_FFFF, 8'h00);
    push_txn(1'b0, 32'h0000_0000, 8'h00);
    push_txn(1'b0, 32'h0000_0001, 8'h00);
    push_done(1'b0, 13, 32'hC433_2211);
    run_access(1'b1, 1'b0, 3'b100, 1'b0, 32'hFFFF_FFFE, 32'h0, 32'hC433_2211, 4, 2);

    // timeout on a load: 4 silent XFER cycles, err and rdata cleared
    push_done(1'b1, 5, 32'h0000_0000);
    run_access(1'b1, 1'b0, 3'b100, 1'b0, 32'h480, 32'h0, 32'h0, 0, 0);

    // both request lines high: store wins
    push_txn(1'b1, 32'h400, 8'h5A);
    push_done(1'b0, 2, 32'h0000_0000);
    run_access(1'b1, 1'b1, 3'b001, 1'b0, 32'h400, 32'h1234_565A, 32'h0000_0011, 1, 0);

    // signed half load with negative upper byte
    push_txn(1'b0, 32'h500, 8'h00);
    push_txn(1'b0, 32'h501, 8'h00);
    push_done(1'b0, 3, 32'hFFFF_8001);
    run_access(1'b1, 1'b0, 3'b010, 1'b0, 32'h500, 32'h0, 32'h0000_8001, 2, 0);

    // unsigned byte load, one wait cycle
    push_txn(1'b0, 32'h600, 8'h00);
    push_done(1'b0, 3, 32'h0000_00F0);
    run_access(1'b1, 1'b0, 3'b001, 1'b1, 32'h600, 32'h0, 32'h0000_00F0, 1, 1);

    // illegal size code 000 is a 4-byte store
    push_txn(1'b1, 32'h700, 8'h04);
    push_txn(1'b1, 32'h701, 8'h03);
    push_txn(1'b1, 32'h702, 8'h02);
    push_txn(1'b1, 32'h703, 8'h01);
    push_done(1'b0, 5, 32'h0000_00F0);
    run_access(1'b0, 1'b1, 3'b000, 1'b0, 32'h700, 32'h0102_0304, 32'h0, 4, 0);

    // reset while cnt = 1 of a word load
    push_txn(1'b0, 32'h900, 8'h00);
    MemReadM = 1'b1;
    size = 3'b100;
    unsigned_ld = 1'b0;
    addr = 32'h900;
    step();
    MemReadM = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = 8'hAA;
    step();
    mem_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_state", {62'd0, dbg_state}, 64'd0);
    check("rst_mid_mem_en", {63'd0, mem_en}, 64'd0);
    check("rst_mid_stall", {63'd0, stall}, 64'd0);
    check("rst_mid_rdata", {32'd0, rdata}, 64'd0);
    last_rdata = '0;
    step();

    // byte load after the mid-transfer reset
    push_txn(1'b0, 32'h800, 8'h00);
    push_done(1'b0, 2, 32'h0000_007F);
    run_access(1'b1, 1'b0, 3'b001, 1'b0, 32'h800, 32'h0, 32'h0000_007F, 1, 0);

    repeat (3) step();
    check("txn_queue_empty", 64'(exp_txn_q.size()), 64'd0);
    check("done_queue_empty", 64'(exp_done_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

endmodule
